// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate format codes, base opcodes and ID-stage FSM states.
// Shared by imm_gen and id_stage_ctrl.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } id_state_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    function automatic logic uses_rs1(input fmt_e f);
        return (f == FMT_I) || (f == FMT_S) || (f == FMT_B) || (f == FMT_NONE);
    endfunction

    function automatic logic uses_rs2(input fmt_e f);
        return (f == FMT_S) || (f == FMT_B) || (f == FMT_NONE);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: opcode classification and sign-extended immediate extraction.
// U/J decode is present only when IMM_UJ_FMT_EN is defined.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  fmt_o,
    output logic [63:0] imm_o
);

    fmt_e fmt;

    always_comb begin
        fmt   = FMT_NONE;
        imm_o = '0;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: begin
                fmt   = FMT_I;
                imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
`ifdef IMM_UJ_FMT_EN
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
`endif
            default: ;
        endcase
    end

`ifndef IMM_UJ_FMT_EN
    logic unused_uj;
    assign unused_uj = ^instr_i[19:12];
`endif

    assign fmt_o = fmt;

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: decode-stage register slice with load-use bubble insertion.
// IMM_UJ_FMT_EN (in imm_gen) enables U/J immediate formats.
module id_stage_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [63:0] if_pc,
    output logic        if_ready,
    output logic        id_valid,
    input  logic        ex_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    output logic [63:0] id_imm,
    output logic [2:0]  id_fmt,
    input  logic        flush,
    output logic        lu_stall
);

    id_state_e   state_q, state_d;
    logic [31:0] instr_q;
    logic [63:0] pc_q, imm_q;
    fmt_e        fmt_q, in_fmt;
    logic [4:0]  lu_rd_q, lu_rd_d;
    logic [2:0]  dec_fmt;
    logic [63:0] dec_imm;
    logic [4:0]  rs1, rs2;
    logic        handoff, accept, hazard;

    imm_gen u_imm_gen (
        .instr_i (if_instr),
        .fmt_o   (dec_fmt),
        .imm_o   (dec_imm)
    );

    assign in_fmt  = fmt_e'(dec_fmt);
    assign handoff = (state_q == ST_HOLD) && ex_ready;
    assign accept  = if_valid && if_ready;
    assign rs1     = if_instr[19:15];
    assign rs2     = if_instr[24:20];

    always_comb begin
        lu_rd_d = lu_rd_q;
        if (flush)
            lu_rd_d = '0;
        else if (handoff)
            lu_rd_d = (instr_q[6:0] == OPC_LOAD) ? instr_q[11:7] : 5'd0;
        else if (ex_ready)
            lu_rd_d = '0;
    end

    // Compare against the load that will be in EX when this instr sits in ID
    assign hazard = (lu_rd_d != 5'd0) &&
                    ((uses_rs1(in_fmt) && (rs1 == lu_rd_d)) ||
                     (uses_rs2(in_fmt) && (rs2 == lu_rd_d)));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = ST_EMPTY;
        else if (accept)
            state_d = hazard ? ST_BUBBLE : ST_HOLD;
        else begin
            case (state_q)
                ST_HOLD:   if (handoff) state_d = ST_EMPTY;
                ST_BUBBLE: if (ex_ready) state_d = ST_HOLD;
                default: ;
            endcase
        end
    end

    always_comb begin
        id_valid = (state_q == ST_HOLD);
        lu_stall = (state_q == ST_BUBBLE);
        if_ready = !reset && !flush && ((state_q == ST_EMPTY) || handoff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            fmt_q   <= FMT_NONE;
            lu_rd_q <= '0;
        end else begin
            lu_rd_q <= lu_rd_d;
            if (accept) begin
                instr_q <= if_instr;
                pc_q    <= if_pc;
                imm_q   <= dec_imm;
                fmt_q   <= in_fmt;
            end
        end
    end

    assign id_instr = instr_q;
    assign id_pc    = pc_q;
    assign id_imm   = imm_q;
    assign id_fmt   = fmt_q;

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have upstream ports: if_valid in 1, fetch offers instr; if_instr in 32, instruction; if_pc in 64, its PC; if_ready out 1, ID accepts this cycle.
REQ-003 SHALL have downstream ports: id_valid out 1, ID offers instr to EX; ex_ready in 1, EX accepts; id_instr out 32; id_pc out 64; id_imm out 64, sign-extended immediate; id_fmt out 3, immediate format code.
REQ-004 SHALL have control ports: flush in 1, squash ID contents; lu_stall out 1, high during load-use bubble.

Function
REQ-005 SHALL classify opcode instr[6:0]: I = 0000011/0010011/0011011/1100111; S = 0100011; B = 1100011; U = 0110111/0010111; J = 1101111; all others NONE.
REQ-006 SHALL produce imm: I {i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'h0}; J {i[31],i[19:12],i[20],i[30:21],0}; each sign-extended from its MSB to 64 bits; NONE gives 0.
REQ-007 SHALL register immediate with instr and PC on accept; 1-cycle latency from accept to id_valid.
REQ-008 SHALL implement FSM EMPTY/HOLD/BUBBLE; id_valid = (state==HOLD); lu_stall = (state==BUBBLE).
REQ-009 SHALL define handoff = id_valid && ex_ready; if_ready = !flush && (state==EMPTY || handoff).
REQ-010 SHALL accept when if_valid && if_ready; with no accept, HOLD->EMPTY on handoff, HOLD stays HOLD otherwise, and outputs stay stable while id_valid && !ex_ready.
REQ-011 SHALL track lu_rd (5 bits): on handoff, lu_rd <= rd (i[11:7]) if handed-off instr is a load, else 0; with no handoff and ex_ready=1, lu_rd <= 0; otherwise hold.
REQ-012 SHALL evaluate hazard on accept against next-cycle lu_rd value: hazard when lu_rd != 0 and equals incoming rs1 (i[19:15], formats I/S/B/NONE) or rs2 (i[24:20], formats S/B/NONE); U/J never hazard.
REQ-013 SHALL on accept enter BUBBLE if hazard, else HOLD.
REQ-014 SHALL leave BUBBLE to HOLD after first cycle in BUBBLE with ex_ready=1; stay in BUBBLE while ex_ready=0.
REQ-015 SHALL on flush go to EMPTY, clear lu_rd, drop any concurrent fetch offer; flush overrides accept and handoff.

Reset
REQ-016 SHALL on reset set state EMPTY, id_valid 0, lu_stall 0, id_instr 0, id_pc 0, id_imm 0, id_fmt NONE, lu_rd 0; reset mid-operation discards held instruction.
REQ-017 SHALL drive if_ready 0 while reset is asserted.

Configuration
REQ-018 SHALL use macro IMM_UJ_FMT_EN: defined, U/J decoded per REQ-005/006; undefined, U/J opcodes classify as NONE with imm 0 and U/J decode logic absent.

Structure
REQ-019 SHALL place fmt codes (NONE=0,I=1,S=2,B=3,U=4,J=5) and opcode constants in shared package riscv_pkg.
REQ-020 SHALL place combinational classification and immediate extraction in sub-module imm_gen; FSM, registers, lu_rd in id_stage_ctrl.

Verification
REQ-021 SHALL test: 0xFFF10093 (addi x1,x2,-1) accepted -> next cycle id_valid=1, id_fmt=I, id_imm=64'hFFFF_FFFF_FFFF_FFFF.
REQ-022 SHALL test: 0xFE112E23 (sw) -> id_imm=64'hFFFF_FFFF_FFFF_FFFC, fmt S; 0x00208863 (beq +16) -> id_imm=64'h10, fmt B.
REQ-023 SHALL test: 0x0000A283 (lw x5) handed off, then add x6,x5,x7 accepted same cycle -> one cycle lu_stall=1/id_valid=0, then id_valid=1; rd=x0 load -> no bubble.
REQ-024 SHALL test: ex_ready low 3 cycles with id_valid=1 -> id_* stable, if_ready=0; release -> handoff and accept same cycle.
REQ-025 SHALL test: flush with if_valid=1 in HOLD -> next cycle id_valid=0, offered instr never appears.
REQ-026 SHALL test: 0x123452B7 (lui) -> with IMM_UJ_FMT_EN id_imm=64'h12345000 fmt U; without, id_imm=0 fmt NONE.
